// File: rtl/fpsqrt_sp_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpsqrt_sp_arbiter_if
// Bundles every handshake and data signal of fpsqrt_sp_arbiter. It covers the
// requester side, the result side and the link to the shared sqrt unit.
//
// Handshake rule (applies to req_* and res_*): a beat transfers on a rising
// clk edge where valid and ready are both 1. The sender holds valid and data
// steady until that edge. ready may depend combinationally on valid, but
// valid never depends on ready.
//
// Signals
//   req_valid [NUM_REQ]     per-requester operand valid
//   req_x     [NUM_REQ*34]  per-requester operand, slice i = [34*i +: 34]
//   req_ready [NUM_REQ]     one-hot grant
//   res_valid / res_id / res_r / res_ready   tagged result stream
//   sqrt_ce / sqrt_x / sqrt_r                 link to the pipelined sqrt unit
// Modports
//   slave  : the arbiter's view
//   master : the surrounding environment (requesters, sink, sqrt unit)
// ---------------------------------------------------------------------------
interface fpsqrt_sp_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*34-1:0] req_x;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [33:0]           res_r;
    logic                  res_ready;
    logic                  sqrt_ce;
    logic [33:0]           sqrt_x;
    logic [33:0]           sqrt_r;

    modport slave (
        input  req_valid, req_x, res_ready, sqrt_r,
        output req_ready, res_valid, res_id, res_r, sqrt_ce, sqrt_x
    );

    modport master (
        output req_valid, req_x, res_ready, sqrt_r,
        input  req_ready, res_valid, res_id, res_r, sqrt_ce, sqrt_x
    );
endinterface

// File: rtl/fpsqrt_sp_arbiter.sv
// ---------------------------------------------------------------------------
// fpsqrt_sp_arbiter
// Shares one pipelined single-precision FloPoCo square-root unit between
// NUM_REQ requesters. A round-robin grant issues at most one operand per
// cycle. A tag pipe, advanced in lockstep with the unit, carries the
// requester ID. The tag reaches the output together with the unit's result.
// Backpressure on the result freezes both the unit (sqrt_ce=0) and the tag pipe.
//
// Ports
//   clk, rst  clock; asynchronous active-high reset
//   bus       fpsqrt_sp_arbiter_if.slave (req_*, res_*, sqrt_* signals)
// Optional (macro FPSQRT_SP_ARB_PERF_EN)
//   perf_clr                   synchronous clear of all counters (wins over increments)
//   perf_issued[31:0]          operands issued
//   perf_stall[31:0]           cycles frozen by result backpressure
//   perf_idle[31:0]            unfrozen cycles without an issue
// Parameters
//   NUM_REQ  number of requesters (>=2)
//   LATENCY  sqrt unit depth in ce-cycles (>=1)
// ---------------------------------------------------------------------------
module fpsqrt_sp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 16,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                rst,
    fpsqrt_sp_arbiter_if.slave bus
`ifdef FPSQRT_SP_ARB_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_idle
`endif
);

    logic [LATENCY:1] tag_v_q, tag_v_d;
    logic [IDW-1:0]   tag_id_q [1:LATENCY];
    logic [IDW-1:0]   tag_id_d [1:LATENCY];
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic             stall;
    logic             sqrt_ce;
    logic             issue;
    logic [IDW-1:0]   grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [33:0]      grant_x;

    // A result waiting at the output with no taker freezes everything. This
    // keeps the unit's result aligned with the tag at stage LATENCY.
    assign stall   = tag_v_q[LATENCY] & ~bus.res_ready;
    assign sqrt_ce = ~stall;

    // Round-robin search starting at rr_ptr. No grant is given while frozen,
    // because the unit cannot accept an operand then.
    always_comb begin
        logic [IDW-1:0] idx;
        idx      = '0;
        grant    = '0;
        grant_id = '0;
        grant_x  = '0;
        issue    = 1'b0;
        if (!stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!issue && bus.req_valid[idx]) begin
                    issue       = 1'b1;
                    grant_id    = idx;
                    grant[idx]  = 1'b1;
                    grant_x     = bus.req_x[34*int'(idx) +: 34];
                end
            end
        end
    end

    // Tag pipe advances only with sqrt_ce. An idle cycle injects a bubble
    // (tag_v=0), so stale unit contents are never reported.
    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        rr_ptr_d = rr_ptr_q;
        if (sqrt_ce) begin
            tag_v_d[1]  = issue;
            tag_id_d[1] = grant_id;
            for (int k = 2; k <= LATENCY; k++) begin
                tag_v_d[k]  = tag_v_q[k-1];
                tag_id_d[k] = tag_id_q[k-1];
            end
        end
        if (issue) begin
            rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_q <= '0;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = tag_v_q[LATENCY];
    assign bus.res_id    = tag_id_q[LATENCY];
    assign bus.res_r     = bus.sqrt_r;
    assign bus.sqrt_ce   = sqrt_ce;
    assign bus.sqrt_x    = grant_x;

`ifdef FPSQRT_SP_ARB_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_idle_q, perf_idle_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(issue);
        perf_stall_d  = perf_stall_q + 32'(stall);
        perf_idle_d   = perf_idle_q + 32'(sqrt_ce & ~issue);
        if (perf_clr) begin
            perf_issued_d = '0;
            perf_stall_d  = '0;
            perf_idle_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
            perf_idle_q   <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
            perf_idle_q   <= perf_idle_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
    assign perf_idle   = perf_idle_q;
`endif

endmodule
